// File: rtl/servant_dbus_demux_pkg.sv
// Shared types and helpers for the servant data-bus demux.
package servant_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Read data returned for unmapped accesses, timeouts and writes.
  localparam logic [31:0] RDT_ERR = 32'h0;

  function automatic int idx_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/servant_dbus_demux.sv
// Routes the SERV dbus Wishbone access to one of NUM_SLAVES ports by high address bits.
// Optional SERVANT_DEMUX_ERRCNT_EN adds a sticky error flag and saturating error counter.
module servant_dbus_demux
  import servant_demux_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          SEL_MSB    = 31,
  parameter int          SEL_LSB    = 30,
  parameter logic [15:0] LOCAL_ACK  = 16'b1110,
  parameter int          TIMEOUT    = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_wb_cpu_adr,
  input  logic [31:0]              i_wb_cpu_dat,
  input  logic [3:0]               i_wb_cpu_sel,
  input  logic                     i_wb_cpu_we,
  input  logic                     i_wb_cpu_cyc,
  output logic [31:0]              o_wb_cpu_rdt,
  output logic                     o_wb_cpu_ack,
  output logic [31:0]              o_wb_s_adr,
  output logic [31:0]              o_wb_s_dat,
  output logic [3:0]               o_wb_s_sel,
  output logic                     o_wb_s_we,
  output logic [NUM_SLAVES-1:0]    o_wb_s_cyc,
  input  logic [32*NUM_SLAVES-1:0] i_wb_s_rdt,
  input  logic [NUM_SLAVES-1:0]    i_wb_s_ack
`ifdef SERVANT_DEMUX_ERRCNT_EN
  ,
  output logic                     o_err,
  output logic [7:0]               o_err_cnt
`endif
);

  localparam int SELW  = SEL_MSB - SEL_LSB + 1;
  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CW    = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [31:0]             adr_q, dat_q;
  logic [3:0]              sel_q;
  logic                    we_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             rdt_q, rdt_d;

  logic [31:0]             sel_ext;
  logic                    mapped;
  logic                    capture;
  logic                    ack_sel;
  logic [31:0]             rdt_sel;
  logic [NUM_SLAVES-1:0]   cyc_dec;
  logic                    timeout;
  logic                    err_evt;

  always_comb begin
    sel_ext = '0;
    sel_ext[SELW-1:0] = i_wb_cpu_adr[SEL_MSB:SEL_LSB];
    mapped  = sel_ext < 32'(NUM_SLAVES);
    capture = (state_q == IDLE) && i_wb_cpu_cyc;

    ack_sel = 1'b0;
    rdt_sel = '0;
    cyc_dec = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        ack_sel    = LOCAL_ACK[n] | i_wb_s_ack[n];
        rdt_sel    = i_wb_s_rdt[32*n +: 32];
        cyc_dec[n] = 1'b1;
      end
    end
    timeout = (cnt_q == CW'(TIMEOUT - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    rdt_d   = rdt_q;
    err_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          cnt_d = '0;
          if (mapped) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            rdt_d   = RDT_ERR;
            err_evt = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A slave ack on the last allowed cycle still delivers its data.
        if (ack_sel) begin
          state_d = RESP;
          rdt_d   = we_q ? RDT_ERR : rdt_sel;
        end else if (timeout) begin
          state_d = RESP;
          rdt_d   = RDT_ERR;
          err_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdt_q   <= rdt_d;
      if (capture) begin
        adr_q <= i_wb_cpu_adr;
        dat_q <= i_wb_cpu_dat;
        sel_q <= i_wb_cpu_sel;
        we_q  <= i_wb_cpu_we;
        idx_q <= i_wb_cpu_adr[SEL_LSB +: IDX_W];
      end
    end
  end

`ifdef SERVANT_DEMUX_ERRCNT_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (err_evt) begin
      err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
`endif

  assign o_wb_cpu_rdt = rdt_q;
  assign o_wb_cpu_ack = (state_q == RESP);
  assign o_wb_s_adr   = adr_q;
  assign o_wb_s_dat   = dat_q;
  assign o_wb_s_sel   = sel_q;
  assign o_wb_s_we    = we_q;
  assign o_wb_s_cyc   = (state_q == WAIT) ? cyc_dec : '0;

endmodule

// File: tb/tb_servant_dbus_demux.sv
// Directed bench for servant_dbus_demux: three slaves (0 acking, 1-2 local ack), TIMEOUT 15.
module tb_servant_dbus_demux;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cpu_adr = '0;
  logic [31:0]   cpu_dat = '0;
  logic [3:0]    cpu_sel = '0;
  logic          cpu_we  = 1'b0;
  logic          cpu_cyc = 1'b0;
  logic [31:0]   cpu_rdt;
  logic          cpu_ack;
  logic [31:0]   s_adr, s_dat;
  logic [3:0]    s_sel;
  logic          s_we;
  logic [NS-1:0] s_cyc;
  logic [32*NS-1:0] s_rdt = '0;
  logic [NS-1:0] s_ack = '0;
`ifdef SERVANT_DEMUX_ERRCNT_EN
  logic          err;
  logic [7:0]    err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  servant_dbus_demux #(
    .NUM_SLAVES(NS), .SEL_MSB(31), .SEL_LSB(30),
    .LOCAL_ACK(16'b0110), .TIMEOUT(15)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
    .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
    .o_wb_cpu_rdt(cpu_rdt), .o_wb_cpu_ack(cpu_ack),
    .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel), .o_wb_s_we(s_we),
    .o_wb_s_cyc(s_cyc), .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack)
`ifdef SERVANT_DEMUX_ERRCNT_EN
    , .o_err(err), .o_err_cnt(err_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic [31:0] exp_err, input logic [31:0] exp_cnt);
`ifdef SERVANT_DEMUX_ERRCNT_EN
    check_eq({tag, "_err"}, 32'(err), exp_err);
    check_eq({tag, "_errcnt"}, 32'(err_cnt), exp_cnt);
`else
    if (exp_err === 32'hFFFF_FFFF || exp_cnt === 32'hFFFF_FFFF) $display("note: %s", tag);
`endif
  endtask

  // Issue one access; slave 0 acks in WAIT cycle ack_at (0 = never). Cycle 1 is the cycle after cyc is sampled.
  task automatic run_case(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we, input int ack_at,
                          input logic [31:0] rdt0, input int exp_lat, input int exp_ncyc,
                          input logic [NS-1:0] exp_cyc, input logic [31:0] exp_rdt);
    int lat, ncyc;
    logic [NS-1:0] cyc_seen;
    logic [31:0] rdt, dat_seen, adr_seen;
    logic [3:0] sel_seen;
    logic we_seen;
    lat = 0; ncyc = 0; cyc_seen = '0; rdt = 'x;
    dat_seen = '0; adr_seen = '0; sel_seen = '0; we_seen = 1'b0;
    @(negedge clk);
    cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_cyc = 1'b1;
    s_rdt[31:0] = rdt0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_cyc != '0) begin
        ncyc++;
        cyc_seen |= s_cyc;
        dat_seen = s_dat; adr_seen = s_adr; sel_seen = s_sel; we_seen = s_we;
      end
      s_ack = (k == ack_at) ? 3'b001 : 3'b000;
      if (cpu_ack) begin
        lat = k;
        rdt = cpu_rdt;
        break;
      end
    end
    cpu_cyc = 1'b0;
    s_ack = '0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_ncyc"}, 32'(ncyc), 32'(exp_ncyc));
    check_eq({tag, "_cyc"}, 32'(cyc_seen), 32'(exp_cyc));
    check_eq({tag, "_rdt"}, rdt, exp_rdt);
    if (exp_ncyc > 0) begin
      check_eq({tag, "_sadr"}, adr_seen, adr);
      check_eq({tag, "_sdat"}, dat_seen, dat);
      check_eq({tag, "_ssel"}, 32'(sel_seen), 32'(sel));
      check_eq({tag, "_swe"}, 32'(we_seen), 32'(we));
    end
    @(negedge clk);
    check_eq({tag, "_ackpulse"}, 32'(cpu_ack), 32'd0);
    check_eq({tag, "_rdthold"}, cpu_rdt, exp_rdt);
  endtask

  initial begin
    s_rdt[63:32] = 32'h1111_1111;
    s_rdt[95:64] = 32'hCAFE_0002;
    #2;
    check_eq("rst_cyc", 32'(s_cyc), 32'd0);
    check_eq("rst_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_rdt", cpu_rdt, 32'd0);
    check_eq("rst_sadr", s_adr, 32'd0);
    check_err("rst", 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_case("rd0", 32'h0000_0010, 32'h0, 4'hF, 1'b0, 3, 32'hDEAD_BEEF, 4, 3, 3'b001, 32'hDEAD_BEEF);
    run_case("wr1", 32'h4000_0000, 32'h5A, 4'b0001, 1'b1, 0, 32'h0, 2, 1, 3'b010, 32'h0);
    run_case("tmoack", 32'h0000_0020, 32'h0, 4'hF, 1'b0, 15, 32'h1234, 16, 15, 3'b001, 32'h1234);
    check_err("tmoack", 0, 0);
    run_case("hung", 32'h0000_0030, 32'h0, 4'hF, 1'b0, 0, 32'h7777, 16, 15, 3'b001, 32'h0);
    check_err("hung", 1, 1);
    run_case("rd2", 32'h8000_0004, 32'h0, 4'hF, 1'b0, 0, 32'h0, 2, 1, 3'b100, 32'hCAFE_0002);
    run_case("unmap", 32'hC000_0000, 32'h0, 4'hF, 1'b0, 0, 32'h0, 1, 0, 3'b000, 32'h0);
    check_err("unmap", 1, 2);
    run_case("rd2b", 32'h8000_0008, 32'h0, 4'hF, 1'b0, 0, 32'h0, 2, 1, 3'b100, 32'hCAFE_0002);

    // Reset in the middle of a WAIT on slave 0.
    @(negedge clk);
    cpu_adr = 32'h0000_0040; cpu_we = 1'b0; cpu_cyc = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_pre", 32'(s_cyc), 32'b001);
    rst = 1'b1;
    #1;
    check_eq("midrst_cyc", 32'(s_cyc), 32'd0);
    check_eq("midrst_ack", 32'(cpu_ack), 32'd0);
    check_eq("midrst_rdt", cpu_rdt, 32'd0);
    check_err("midrst", 0, 0);
    cpu_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_case("postrst", 32'h0000_0044, 32'h0, 4'hF, 1'b0, 2, 32'hABCD_0001, 3, 2, 3'b001, 32'hABCD_0001);
    check_err("postrst", 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servant_dbus_demux.md
Name: servant_dbus_demux

Overview:
- Parametrised successor to the fixed servant data-bus mux.
- Routes the SERV data-bus Wishbone transaction to one of NUM_SLAVES peripheral ports, selected by high address bits.
- Registers request and response, and generates a local ack for ack-less slaves (GPIO, timer, accelerator regs).
- Terminates unmapped or hung accesses with a timeout so the core never stalls.
- Sits between serv_rf_top dbus and the arbiter/peripherals in the servant top.

Parameters:
- NUM_SLAVES, 4, number of slave ports (2..16).
- SEL_MSB, 31, MSB of the slave-index field in i_wb_cpu_adr.
- SEL_LSB, 30, LSB of the slave-index field; width SEL_MSB-SEL_LSB+1 must cover NUM_SLAVES.
- LOCAL_ACK, 4'b1110, bit n=1 means slave n has no ack; demux acks it after one WAIT cycle.
- TIMEOUT, 15, max WAIT cycles before forced termination (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wb_cpu_adr  in  32  CPU address.
- i_wb_cpu_dat  in  32  CPU write data.
- i_wb_cpu_sel  in  4  byte enables.
- i_wb_cpu_we  in  1  write enable.
- i_wb_cpu_cyc  in  1  request valid.
- o_wb_cpu_rdt  out  32  read data, registered.
- o_wb_cpu_ack  out  1  one-cycle ack, registered.
- o_wb_s_adr  out  32  captured address, broadcast to all slaves.
- o_wb_s_dat  out  32  captured write data, broadcast.
- o_wb_s_sel  out  4  captured sel, broadcast.
- o_wb_s_we  out  1  captured we, broadcast.
- o_wb_s_cyc  out  NUM_SLAVES  one-hot cyc.
- i_wb_s_rdt  in  32*NUM_SLAVES  slave n read data at [32n+31:32n].
- i_wb_s_ack  in  NUM_SLAVES  slave acks; ignored where LOCAL_ACK bit set.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0: o_wb_s_cyc=0, o_wb_cpu_ack=0, o_wb_cpu_rdt=0.
  - Captured adr/dat/sel/we=0; timeout counter=0.
  - A transaction in flight is dropped; the CPU is reset with it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On i_wb_cpu_cyc=1: capture adr/dat/sel/we and idx=adr[SEL_MSB:SEL_LSB].
  - If idx<NUM_SLAVES, go to WAIT.
  - Otherwise (unmapped), go to RESP with rdt=0.
- WAIT:
  - o_wb_s_cyc[idx]=1 and all other bits 0. Counter increments each cycle.
  - Completion when LOCAL_ACK[idx] | i_wb_s_ack[idx]:
    - rdt <= i_wb_s_rdt slice idx (0 if we=1);
    - go to RESP;
    - o_wb_s_cyc drops on the same edge.
  - Timeout when counter==TIMEOUT-1 with no ack: rdt <= 0, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins and its data is returned.
- RESP: o_wb_cpu_ack=1 for exactly one cycle, then IDLE unconditionally.
- i_wb_cpu_cyc is not sampled in RESP. It is sampled again in IDLE the cycle after; SERV has dropped cyc by then.
- Latency (request in cycle t):
  - acking slave answers in cycle k>=t+1 -> o_wb_cpu_ack in k+1;
  - local-ack slave -> ack at t+2;
  - unmapped -> ack at t+1.
- i_wb_cpu_cyc falling during WAIT is ignored; the transaction completes. SERV never does this.
- o_wb_cpu_rdt holds its value until the next capture.
- Counter width: $clog2(TIMEOUT+1). Counter clears on entry to WAIT.

Optional Feature:
- Macro: SERVANT_DEMUX_ERRCNT_EN.
- When defined:
  - adds o_err (1, sticky, set by any timeout or unmapped access, cleared only by reset);
  - adds o_err_cnt (8, saturating at 255, +1 per error event);
  - both reset to 0.
- When undefined: ports absent, no extra logic; all other behaviour identical.

Decomposition:
- Package servant_demux_pkg:
  - state enum {IDLE, WAIT, RESP} (2 bits);
  - function idx_width(NUM_SLAVES);
  - constant RDT_ERR=32'h0.
- No sub-module; the counter and FSM stay flat in one module.

Test Plan:
- Read slave 0 (acking, adr=32'h0000_0010, slave acks 3 cycles after cyc, rdt=32'hDEAD_BEEF) -> o_wb_s_cyc=4'b0001 for 3 cycles, o_wb_cpu_ack one cycle later with rdt=32'hDEAD_BEEF.
- Write slave 1 (local ack, adr=32'h4000_0000, dat=32'h5A, sel=4'b0001) -> o_wb_s_cyc[1] exactly one cycle with broadcast dat=32'h5A, o_wb_cpu_ack at t+2, rdt=0.
- Hung slave 0 (never acks), TIMEOUT=15 -> cyc high 15 cycles, ack with rdt=0; with macro, o_err=1 and o_err_cnt=1.
- Unmapped (NUM_SLAVES=3, adr=32'hC000_0000) -> no o_wb_s_cyc, ack at t+1, rdt=0.
- Ack on the timeout cycle (slave 0 acks in WAIT cycle 15, rdt=32'h1234) -> returns 32'h1234, no error count.
- i_rst pulsed mid-WAIT -> o_wb_s_cyc and o_wb_cpu_ack go 0 immediately; after release, the next request completes normally.
